// File: rtl/piso_frame_transmitter_pkg.sv
// ---------------------------------------------------------------------------
// piso_frame_transmitter_pkg
//   Frame state encodings for the serial frame transmitter. The same values
//   are used by the matching serial-in/parallel-out receiver, so a state
//   probe on either end of the link reads the same way.
//   No ports.
// ---------------------------------------------------------------------------
package piso_frame_transmitter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/piso_frame_transmitter_bit_period_counter.sv
// ---------------------------------------------------------------------------
// bit_period_counter
//   Counts the CLKS_PER_BIT clock cycles of one serial bit and raises
//   registered flags for the first and the last cycle of each bit.
//   The flags describe the cycle currently on the line, so they can drive
//   outputs directly.
//
//   clk     in   system clock, rising edge
//   rst     in   asynchronous reset, active-high
//   clear   in   next cycle is the first cycle of a new frame
//   enable  in   current cycle belongs to a frame that continues next cycle
//   first   out  current cycle is the first cycle of a bit
//   last    out  current cycle is the last cycle of a bit
// ---------------------------------------------------------------------------
module bit_period_counter #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic first,
  output logic last
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // Count value one cycle before the end of a bit; unused when a bit is a
  // single cycle long because last is then always set during a frame.
  localparam logic [CW-1:0] PENULT = CW'((CLKS_PER_BIT > 1) ? (CLKS_PER_BIT - 2) : 0);
  localparam logic          SINGLE = (CLKS_PER_BIT == 1);

  if (CLKS_PER_BIT < 1) begin : g_param_check
    $error("bit_period_counter: CLKS_PER_BIT must be at least 1");
  end

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      first <= 1'b0;
      last  <= 1'b0;
    end else if (clear) begin
      cnt_q <= '0;
      first <= 1'b1;
      last  <= SINGLE;
    end else if (enable) begin
      if (last) begin
        // wrap into the first cycle of the following bit
        cnt_q <= '0;
        first <= 1'b1;
        last  <= SINGLE;
      end else begin
        cnt_q <= cnt_q + 1'b1;
        first <= 1'b0;
        last  <= (cnt_q == PENULT);
      end
    end else begin
      cnt_q <= '0;
      first <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_frame_transmitter.sv
// ---------------------------------------------------------------------------
// piso_frame_transmitter
//   Parallel-in, serial-out framed transmitter. A word presented with a
//   one-cycle load strobe is sent MSB-first as: low start bit, WIDTH data
//   bits, high stop bit. Each bit lasts CLKS_PER_BIT clock cycles.
//
//   Handshake: a frame starts on a rising edge where load=1 and ready=1;
//   din is captured on that edge only. load while ready=0 is ignored.
//
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active-high
//   load        in   start-frame request
//   din         in   WIDTH-bit word to send
//   ready       out  idle, a load will be accepted
//   sout        out  serial line, idles high
//   bit_strobe  out  pulse on the first cycle of every bit
//   done        out  pulse on the last cycle of the stop bit
// ---------------------------------------------------------------------------
module piso_frame_transmitter
  import piso_frame_transmitter_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int Delay        = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             sout,
  output logic             bit_strobe,
  output logic             done
);

  localparam int            BW       = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  // Delay only shapes simulation timing in the gate-level flavour of this
  // catalog; it has no effect on the logic here.
  if (WIDTH < 1 || CLKS_PER_BIT < 1 || Delay < 0) begin : g_param_check
    $error("piso_frame_transmitter: WIDTH and CLKS_PER_BIT must be >= 1, Delay >= 0");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             sout_q, sout_d;
  logic             ready_q;
  logic             period_clear, period_enable;
  logic             period_first, period_last;

  // The period counter is restarted on an accepted load and runs for every
  // frame cycle except the final stop cycle, so its flags drop to zero in
  // the idle cycle that follows done.
  assign period_clear  = (state_q == ST_IDLE) && load;
  assign period_enable = (state_q == ST_START) || (state_q == ST_DATA) ||
                         ((state_q == ST_STOP) && !period_last);

  bit_period_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_period (
    .clk    (clk),
    .rst    (rst),
    .clear  (period_clear),
    .enable (period_enable),
    .first  (period_first),
    .last   (period_last)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          shift_d   = din;
          bit_cnt_d = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (period_last) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (period_last) begin
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (period_last) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Line level for the cycle that the next state describes; anything that
  // is not a start or data cycle drives the idle/stop level.
  always_comb begin
    sout_d = 1'b1;
    case (state_d)
      ST_START: sout_d = 1'b0;
      ST_DATA:  sout_d = shift_d[WIDTH-1];
      default:  sout_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      sout_q    <= 1'b1;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      sout_q    <= sout_d;
      ready_q   <= (state_d == ST_IDLE);
    end
  end

  assign ready      = ready_q;
  assign sout       = sout_q;
  assign bit_strobe = period_first;
  // Built only from flops, so no input reaches done within a cycle.
  assign done       = (state_q == ST_STOP) && period_last;

endmodule
